ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit in the EX stage, fed by the ID/EX pipeline register outputs.
//  Executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
//  Asserts a stall while an operation is in flight, so that the hazard unit freezes IF/ID/ID-EX.
// PARAMETERS
//  DATA_W   32   operand/HI/LO width; iteration count = DATA_W
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  i_valid    in   1       EX holds a valid R-type instruction (ALUOp=R-type)
//  i_flush    in   1       squash the EX instruction; suppresses start and MT write
//  i_funct    in   6       funct field from ID/EX
//  i_a        in   DATA_W  rs operand (after forwarding)
//  i_b        in   DATA_W  rt operand (after forwarding)
//  o_busy     out  1       operation in flight (state != IDLE)
//  o_stall    out  1       stall request to the hazard unit
//  o_done     out  1       1-cycle pulse in FIX state
//  o_mf_data  out  DATA_W  HI or LO value for MFHI/MFLO, else 0
//  o_hi       out  DATA_W  architectural HI
//  o_lo       out  DATA_W  architectural LO
// BEHAVIOUR
//  - funct: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
//    muldiv-class = any of these. Other functs: no effect.
//  - reset: state=IDLE, HI=LO=0, counter=0, o_busy=0, o_done=0.
//  - o_stall = i_valid & muldiv-class & o_busy. This is combinational and holds the instruction in EX.
//  - Start: on an edge with IDLE & i_valid & !i_flush & funct in {MULT,MULTU,DIV,DIVU}:
//    latch |a|, |b| (magnitudes for signed ops only), sign_a, sign_b, op and div_by_zero.
//    Clear counter, then go to MUL or DIV.
//  - MUL: one shift-add step per cycle on the 2*DATA_W accumulator. The counter counts 0..DATA_W-1,
//    and the state moves to FIX when the counter = DATA_W-1.
//  - DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
//    Same counter rule.
//  - FIX (1 cycle): o_done=1. Apply the sign fixup and write HI/LO on the FIX->IDLE edge.
//    - MULT: negate the 64-bit product if sign_a^sign_b.
//    - DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a (truncating division).
//  - Latency: start edge at cycle k gives MUL/DIV in cycles k+1..k+32 and FIX at k+33.
//    IDLE and new HI/LO are visible from k+34. o_busy is high for 33 cycles.
//  - Divide by zero (i_b==0): iterations still run with full latency. Result is HI=i_a, LO=all-ones,
//    for both DIV and DIVU.
//  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. There is no trap.
//  - MTHI/MTLO: in IDLE, with i_valid & !i_flush, write i_a to HI/LO on the edge.
//    While busy these are stalled.
//  - MFHI/MFLO: o_mf_data = HI/LO combinationally when IDLE. Stalled while busy.
//  - A new mul/div while busy is stalled and is never queued. A start and an MT are never simultaneous.
//  - i_flush while busy has no effect: the operation in flight completes and commits.
//  - reset mid-operation aborts immediately to IDLE with HI=LO=0.
// STRUCTURE
//  - Shared package muldiv_pkg holds the funct localparams, the state enum {IDLE,MUL,DIV,FIX}, and
//    the is_muldiv()/is_start() decode functions.
//  - Sub-module muldiv_iter_core holds the accumulator and remainder/quotient shift registers and
//    one-step add/subtract. It is controlled by step/load/mode from the FSM in this module.
//  - The HI/LO registers, sign fixup and stall logic stay in this top module.
// TESTING
//  1. MULT a=0xFFFFFFFE b=3 -> at k+34 HI=0xFFFFFFFF, LO=0xFFFFFFFA. o_busy is high for 33 cycles.
//     o_done pulses at k+33.
//  2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//  3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIVU 7/0 -> HI=0x00000007, LO=0xFFFFFFFF, with full latency.
//  4. MFLO presented 1 cycle after a MULT start -> o_stall=1 until IDLE.
//     Then o_mf_data = the new LO and o_stall=0.
//  5. MTHI 0x12345678 in IDLE, then MFHI -> o_mf_data=0x12345678 with no stall.
//     A MULT with i_flush=1 does not start (o_busy stays 0).
//  6. Assert reset in the 10th DIV cycle -> o_busy=0 and HI=LO=0 immediately.
//     A following DIVU 100/7 gives LO=14, HI=2.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the EX-stage HI/LO multiply/divide unit:
//   funct codes of the HI/LO instruction group, the controller state encoding
//   and small decode helpers used by the unit and its interface.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    // funct field codes of the HI/LO instruction group
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    // Controller state: IDLE accepts work, MUL/DIV iterate, FIX commits HI/LO
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Any instruction that touches HI/LO (and therefore must wait while busy)
    function automatic logic is_muldiv(input logic [5:0] funct);
        return (funct == F_MFHI)  || (funct == F_MTHI)  ||
               (funct == F_MFLO)  || (funct == F_MTLO)  ||
               (funct == F_MULT)  || (funct == F_MULTU) ||
               (funct == F_DIV)   || (funct == F_DIVU);
    endfunction

    // Instructions that launch an iterative operation
    function automatic logic is_start(input logic [5:0] funct);
        return (funct == F_MULT) || (funct == F_MULTU) ||
               (funct == F_DIV)  || (funct == F_DIVU);
    endfunction

    // Signed flavours take operand magnitudes and need a sign fixup at the end
    function automatic logic is_signed_op(input logic [5:0] funct);
        return (funct == F_MULT) || (funct == F_DIV);
    endfunction

    function automatic logic is_div_op(input logic [5:0] funct);
        return (funct == F_DIV) || (funct == F_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit_if
//   Connection between the EX stage (master) and the HI/LO multiply/divide
//   unit (slave).
//   Master drives : i_valid, i_flush, i_funct, i_a, i_b
//   Slave drives  : o_busy, o_stall, o_done, o_mf_data, o_hi, o_lo,
//                   o_dbg_state (controller state, for observation only)
//
//   Handshake: an instruction is offered whenever i_valid is high. It is taken
//   on a rising clock edge where i_valid=1 and o_stall=0; while o_stall=1 the
//   master must hold i_valid/i_funct/i_a/i_b unchanged. i_flush squashes the
//   offered instruction (no start, no HI/LO write) but does not affect an
//   operation already in flight.
// -----------------------------------------------------------------------------
interface ex_muldiv_unit_if import muldiv_pkg::*; #(
    parameter int DATA_W = 32
) ();

    logic              i_valid;
    logic              i_flush;
    logic [5:0]        i_funct;
    logic [DATA_W-1:0] i_a;
    logic [DATA_W-1:0] i_b;

    logic              o_busy;
    logic              o_stall;
    logic              o_done;
    logic [DATA_W-1:0] o_mf_data;
    logic [DATA_W-1:0] o_hi;
    logic [DATA_W-1:0] o_lo;
    state_t            o_dbg_state;

    modport master (
        output i_valid, i_flush, i_funct, i_a, i_b,
        input  o_busy, o_stall, o_done, o_mf_data, o_hi, o_lo, o_dbg_state
    );

    modport slave (
        input  i_valid, i_flush, i_funct, i_a, i_b,
        output o_busy, o_stall, o_done, o_mf_data, o_hi, o_lo, o_dbg_state
    );

endinterface

// File: rtl/ex_muldiv_unit_iter_core.sv
// -----------------------------------------------------------------------------
// muldiv_iter_core
//   Unsigned iterative datapath shared by multiply and divide.
//   Registers: r_hi (product high half / partial remainder),
//              r_lo (multiplier -> product low half / dividend -> quotient),
//              r_b  (multiplicand / divisor).
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     i_load       capture operand magnitudes, clear r_hi
//     i_step       perform one iteration (ignored on a load cycle)
//     i_mode_div   0: shift-add multiply step, 1: restoring divide step
//     i_a, i_b     unsigned operands (magnitudes)
//     o_hi, o_lo   current r_hi / r_lo contents
//   After DATA_W multiply steps {o_hi,o_lo} = a*b.
//   After DATA_W divide steps  o_lo = a/b, o_hi = a%b (b!=0).
// -----------------------------------------------------------------------------
module muldiv_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_mode_div,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_b;

    logic [DATA_W:0]   w_sum;    // multiply: carry + high half after add
    logic [DATA_W:0]   w_shift;  // divide: remainder shifted left with next dividend bit
    logic [DATA_W:0]   w_trial;  // divide: trial subtraction, MSB set means negative

    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[DATA_W-1]};
        w_trial = w_shift - {1'b0, r_b};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_b  <= i_b;
        end else if (i_step) begin
            if (i_mode_div) begin
                // Restoring step: keep the subtraction only if it did not go negative.
                // The quotient bit enters r_lo as the dividend bit leaves it.
                if (!w_trial[DATA_W]) begin
                    r_hi <= w_trial[DATA_W-1:0];
                    r_lo <= {r_lo[DATA_W-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[DATA_W-1:0];
                    r_lo <= {r_lo[DATA_W-2:0], 1'b0};
                end
            end else begin
                // Shift-add step: the consumed multiplier bit falls off r_lo[0]
                // while the product's low bit enters from the adder.
                r_hi <= w_sum[DATA_W:1];
                r_lo <= {w_sum[0], r_lo[DATA_W-1:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
//   EX-stage HI/LO multiply/divide unit. Executes MULT, MULTU, DIV, DIVU
//   iteratively (one bit per cycle) plus MFHI, MFLO, MTHI, MTLO, and requests
//   a pipeline stall while an HI/LO instruction meets an operation in flight.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; aborts any operation, clears HI/LO
//     bus    ex_muldiv_unit_if.slave:
//              i_valid/i_flush/i_funct/i_a/i_b from ID/EX,
//              o_busy, o_stall, o_done, o_mf_data, o_hi, o_lo, o_dbg_state
//   Timing: start edge at cycle k -> MUL/DIV in k+1..k+DATA_W, FIX at
//   k+DATA_W+1 (o_done), new HI/LO and IDLE from k+DATA_W+2.
// -----------------------------------------------------------------------------
module ex_muldiv_unit import muldiv_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    ex_muldiv_unit_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // Controller and architectural state
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    // Operation context captured at start
    logic                r_sign_a;
    logic                r_sign_b;
    logic                r_is_div;
    logic                r_dbz;
    logic [DATA_W-1:0]   r_a_raw;

    // Decode / control
    logic                w_idle;
    logic                w_take;
    logic                w_start;
    logic                w_mt_hi;
    logic                w_mt_lo;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic                w_step;
    logic                w_mode_div;
    logic                w_last;

    // Datapath results and fixup
    logic [DATA_W-1:0]   w_core_hi;
    logic [DATA_W-1:0]   w_core_lo;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_quot_fix;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;
    logic [DATA_W-1:0]   w_mf_data;

    // ---------------------------------------------------------------- decode
    always_comb begin
        w_idle     = (r_state == IDLE);
        w_take     = w_idle && bus.i_valid && !bus.i_flush;
        w_start    = w_take && is_start(bus.i_funct);
        w_mt_hi    = w_take && (bus.i_funct == F_MTHI);
        w_mt_lo    = w_take && (bus.i_funct == F_MTLO);
        // Signed ops iterate on magnitudes; unsigned ops never look at the MSB
        w_a_neg    = is_signed_op(bus.i_funct) && bus.i_a[DATA_W-1];
        w_b_neg    = is_signed_op(bus.i_funct) && bus.i_b[DATA_W-1];
        w_a_mag    = w_a_neg ? -bus.i_a : bus.i_a;
        w_b_mag    = w_b_neg ? -bus.i_b : bus.i_b;
        w_step     = (r_state == MUL) || (r_state == DIV);
        w_mode_div = (r_state == DIV);
        w_last     = (r_cnt == CNT_LAST);
    end

    muldiv_iter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start),
        .i_step     (w_step),
        .i_mode_div (w_mode_div),
        .i_a        (w_a_mag),
        .i_b        (w_b_mag),
        .o_hi       (w_core_hi),
        .o_lo       (w_core_lo)
    );

    // ------------------------------------------------------------ sign fixup
    // Truncating division: quotient sign is sign_a^sign_b, remainder follows
    // the dividend. Divide-by-zero bypasses the iteration result entirely so
    // both DIV and DIVU report HI=dividend, LO=all-ones.
    always_comb begin
        w_prod     = {w_core_hi, w_core_lo};
        w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
        w_quot_fix = (r_sign_a ^ r_sign_b) ? -w_core_lo : w_core_lo;
        w_rem_fix  = r_sign_a ? -w_core_hi : w_core_hi;
        if (!r_is_div) begin
            w_res_hi = w_prod_fix[2*DATA_W-1:DATA_W];
            w_res_lo = w_prod_fix[DATA_W-1:0];
        end else if (r_dbz) begin
            w_res_hi = r_a_raw;
            w_res_lo = '1;
        end else begin
            w_res_hi = w_rem_fix;
            w_res_lo = w_quot_fix;
        end
    end

    // ------------------------------------------------------------ controller
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_is_div <= 1'b0;
            r_dbz    <= 1'b0;
            r_a_raw  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_sign_a <= w_a_neg;
                        r_sign_b <= w_b_neg;
                        r_is_div <= is_div_op(bus.i_funct);
                        r_dbz    <= (bus.i_b == '0);
                        r_a_raw  <= bus.i_a;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= is_div_op(bus.i_funct) ? DIV : MUL;
                    end
                    // A start and an MT are exclusive by funct decode
                    if (w_mt_hi) begin
                        r_hi <= bus.i_a;
                    end
                    if (w_mt_lo) begin
                        r_lo <= bus.i_a;
                    end
                end
                MUL, DIV: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= FIX;
                        r_done  <= 1'b1;
                    end
                end
                FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        w_mf_data = '0;
        if (w_idle) begin
            if (bus.i_funct == F_MFHI) begin
                w_mf_data = r_hi;
            end else if (bus.i_funct == F_MFLO) begin
                w_mf_data = r_lo;
            end
        end
    end

    // Stall is combinational so the offending instruction stays in EX on the
    // very cycle it meets a busy unit.
    assign bus.o_stall     = bus.i_valid && is_muldiv(bus.i_funct) && r_busy;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_mf_data   = w_mf_data;
    assign bus.o_hi        = r_hi;
    assign bus.o_lo        = r_lo;
    assign bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset;

  ex_muldiv_unit_if #(.DATA_W(W)) bus ();

  ex_muldiv_unit #(.DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    string      name;
    logic [5:0] funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[9];

  // ---------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic on the architectural rules.
  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] uq, ur, res;
    res = '0;
    case (f)
      F_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'(sa * sb);
      end
      F_MULTU: res = {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          uq = 64'(q);
          ur = 64'(r);
          res = {ur[31:0], uq[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic drive_idle();
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_funct = 6'h00;
    bus.i_a     = '0;
    bus.i_b     = '0;
  endtask

  // Issue one mul/div, wait for completion, check timing and scoreboard.
  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] act_hi,
                        output logic [W-1:0] act_lo);
    logic [63:0] r;
    logic [W-1:0] e_hi, e_lo;
    int busy_n, done_at, idle_at;
    r = ref_model(f, a, b);
    exp_q.push_back(r[63:32]);
    exp_q.push_back(r[31:0]);
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_flush = 1'b0; bus.i_funct = f; bus.i_a = a; bus.i_b = b;
    @(posedge clk); #1;
    drive_idle();
    busy_n = 0; done_at = 0; idle_at = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (bus.o_busy) busy_n++;
      if (bus.o_done) done_at = (done_at == 0) ? cyc : -1;
      if (!bus.o_busy) begin
        idle_at = cyc;
        break;
      end
    end
    act_hi = bus.o_hi;
    act_lo = bus.o_lo;
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    check({name, " idle_cycle"}, 64'(idle_at), 64'd34);
    check({name, " busy_cycles"}, 64'(busy_n), 64'd33);
    check({name, " done_cycle"}, 64'(done_at), 64'd33);
    check({name, " hi"}, 64'(act_hi), 64'(e_hi));
    check({name, " lo"}, 64'(act_lo), 64'(e_lo));
  endtask

  // ------------------------------------------------------------------- test
  initial begin
    logic [W-1:0] hi_v, lo_v;
    logic [5:0] rf;
    logic [W-1:0] ra, rb;
    int stall_n, idle_at;

    vecs[0] = '{"mult_neg2x3",     F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{"multu_max",       F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{"div_m7_2",        F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_7_0",        F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{"div_min_m1",      F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{"divu_100_7",      F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[6] = '{"div_m5_0",        F_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{"mult_7_m3",       F_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[8] = '{"div_7_m2",        F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(bus.o_busy), 64'd0);
    check("reset done", 64'(bus.o_done), 64'd0);
    check("reset hi", 64'(bus.o_hi), 64'd0);
    check("reset lo", 64'(bus.o_lo), 64'd0);
    check("reset state", 64'(bus.o_dbg_state), 64'(IDLE));

    // Table-driven vectors: scoreboard (model) plus hand-derived constants
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].name, vecs[i].funct, vecs[i].a, vecs[i].b, hi_v, lo_v);
      check({vecs[i].name, " const_hi"}, 64'(hi_v), 64'(vecs[i].hi));
      check({vecs[i].name, " const_lo"}, 64'(lo_v), 64'(vecs[i].lo));
    end

    // Non-muldiv funct: no start, HI/LO untouched
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_funct = 6'h20; bus.i_a = 32'h1111_1111; bus.i_b = 32'h2;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("other_funct busy", 64'(bus.o_busy), 64'd0);
    check("other_funct hi", 64'(bus.o_hi), 64'h1);
    check("other_funct lo", 64'(bus.o_lo), 64'hFFFF_FFFD);

    // MTHI then MFHI, no stall
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_funct = F_MTHI; bus.i_a = 32'h1234_5678;
    @(posedge clk); #1;
    bus.i_funct = F_MFHI; bus.i_a = '0;
    @(negedge clk);
    check("mthi mf_data", 64'(bus.o_mf_data), 64'h1234_5678);
    check("mfhi stall", 64'(bus.o_stall), 64'd0);
    // Flushed MTLO must not write
    @(posedge clk); #1;
    bus.i_funct = F_MTLO; bus.i_a = 32'hDEAD_BEEF; bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0; bus.i_funct = F_MFLO; bus.i_a = '0;
    @(negedge clk);
    check("mtlo_flush mf_data", 64'(bus.o_mf_data), 64'hFFFF_FFFD);
    @(posedge clk); #1;
    bus.i_funct = F_MTLO; bus.i_a = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.i_funct = F_MFLO; bus.i_a = '0;
    @(negedge clk);
    check("mtlo mf_data", 64'(bus.o_mf_data), 64'hCAFE_F00D);
    // Flushed MULT must not start
    @(posedge clk); #1;
    bus.i_funct = F_MULT; bus.i_a = 32'd5; bus.i_b = 32'd6; bus.i_flush = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("mult_flush busy", 64'(bus.o_busy), 64'd0);
    check("mult_flush state", 64'(bus.o_dbg_state), 64'(IDLE));

    // MFLO presented one cycle after MULT start: stalls until IDLE
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_funct = F_MULT; bus.i_a = 32'h0001_2345; bus.i_b = 32'h0000_0100;
    @(posedge clk); #1;
    bus.i_funct = F_MFLO; bus.i_a = '0; bus.i_b = '0;
    stall_n = 0; idle_at = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (bus.o_stall) stall_n++;
      if (!bus.o_busy) begin
        idle_at = cyc;
        break;
      end
    end
    check("mflo_wait idle_cycle", 64'(idle_at), 64'd34);
    check("mflo_wait stall_cycles", 64'(stall_n), 64'd33);
    check("mflo_wait stall_after", 64'(bus.o_stall), 64'd0);
    check("mflo_wait mf_data", 64'(bus.o_mf_data), 64'h0123_4500);
    drive_idle();

    // MT and flushed MULT while busy: op completes and commits, MT not applied
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_funct = F_MULTU; bus.i_a = 32'h0001_0000; bus.i_b = 32'h0001_0000;
    @(posedge clk); #1;
    bus.i_funct = F_MTHI; bus.i_a = 32'h5555_5555;
    repeat (10) @(posedge clk);
    #1;
    bus.i_funct = F_MULT; bus.i_flush = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    drive_idle();
    idle_at = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (!bus.o_busy) begin
        idle_at = cyc;
        break;
      end
    end
    check("busy_flush reached_idle", 64'(idle_at != 0), 64'd1);
    check("busy_flush hi", 64'(bus.o_hi), 64'h1);
    check("busy_flush lo", 64'(bus.o_lo), 64'h0);

    // Reset in the 10th DIV cycle
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_funct = F_DIV; bus.i_a = 32'd1000; bus.i_b = 32'd3;
    @(posedge clk); #1;
    drive_idle();
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset busy", 64'(bus.o_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_reset busy", 64'(bus.o_busy), 64'd0);
    check("mid_reset hi", 64'(bus.o_hi), 64'd0);
    check("mid_reset lo", 64'(bus.o_lo), 64'd0);
    check("mid_reset state", 64'(bus.o_dbg_state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    run_op("divu_after_reset", F_DIVU, 32'd100, 32'd7, hi_v, lo_v);
    check("divu_after_reset const_hi", 64'(hi_v), 64'd2);
    check("divu_after_reset const_lo", 64'(lo_v), 64'd14);

    // Randomized operations against the reference model
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: rf = F_MULT;
        1: rf = F_MULTU;
        2: rf = F_DIV;
        default: rf = F_DIVU;
      endcase
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d f=%0h a=%0h b=%0h", n, rf, ra, rb), rf, ra, rb, hi_v, lo_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
